// File: rtl/unidad_control_pila.sv
// microc control unit with hardware return-address stack for jal/ret.
// Define UC_HALT_ON_ERR_EN to halt the unit on stack overflow/underflow.
module unidad_control_pila #(
    parameter  int PC_W  = 10,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic            z,
    input  logic [PC_W-1:0] pc_sig,
    output logic            s_inc,
    output logic            s_pila,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [2:0]      op,
    output logic [PC_W-1:0] pc_ret,
    output logic [PW-1:0]   prof,
    output logic            err_pila,
    output logic            parado
);

    typedef enum logic {RUN, HALT} state_t;

    localparam int            SLOTS = 1 << PW;
    localparam logic [PW-1:0] FULL  = PW'(DEPTH);

    state_t          state;
    logic [PC_W-1:0] stack [SLOTS];
    logic            halted;
    logic            is_li, is_addi, is_j, is_jz, is_jnz, is_jal, is_ret;

    assign halted  = (state == HALT);
    assign is_li   = (opcode[5:2] == 4'b0001);
    assign is_addi = (opcode[5:2] == 4'b0011);
    assign is_j    = (opcode == 6'b010000);
    assign is_jz   = (opcode == 6'b010001);
    assign is_jnz  = (opcode == 6'b010010);
    assign is_jal  = (opcode == 6'b010011);
    assign is_ret  = (opcode == 6'b010100);

`ifdef UC_HALT_ON_ERR_EN
    assign parado = halted;
`else
    assign parado = 1'b0;
`endif

    assign pc_ret = (prof == '0) ? '0 : stack[prof - 1'b1];

    always_comb begin
        s_inc  = 1'b0;
        s_pila = 1'b0;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        op     = 3'b000;
        if (!halted) begin
            unique case (1'b1)
                opcode[5]: begin
                    s_inc = 1'b1;
                    we3   = 1'b1;
                    wez   = 1'b1;
                    op    = opcode[4:2];
                end
                is_li: begin
                    s_inc = 1'b1;
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end
                is_addi: begin
                    s_inc = 1'b1;
                    s_inm = 1'b1;
                    we3   = 1'b1;
                    op    = 3'b010;
                end
                is_j:    s_inc  = 1'b0;
                is_jz:   s_inc  = ~z;
                is_jnz:  s_inc  = z;
                is_jal:  s_inc  = 1'b0;
                is_ret:  s_pila = 1'b1;
                default: s_inc  = 1'b1;
            endcase
        end
    end

    // Faulting push/pop only latches the error; stack contents are kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            prof     <= '0;
            err_pila <= 1'b0;
            for (int i = 0; i < SLOTS; i++)
                stack[i] <= '0;
        end else if (!halted) begin
            if (is_jal) begin
                if (prof == FULL) begin
                    err_pila <= 1'b1;
`ifdef UC_HALT_ON_ERR_EN
                    state    <= HALT;
`endif
                end else begin
                    stack[prof] <= pc_sig;
                    prof        <= prof + 1'b1;
                end
            end else if (is_ret) begin
                if (prof == '0) begin
                    err_pila <= 1'b1;
`ifdef UC_HALT_ON_ERR_EN
                    state    <= HALT;
`endif
                end else begin
                    prof <= prof - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_unidad_control_pila.sv
// Scoreboard bench for unidad_control_pila (PC_W=10, DEPTH=4).
// Covers decode, call/return, overflow, underflow and async reset.
module tb_unidad_control_pila;

    localparam int PC_W = 10;
    localparam int DEPTH = 4;
    localparam int PW = $clog2(DEPTH + 1);
`ifdef UC_HALT_ON_ERR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    typedef logic [22:0] vec_t;
    typedef struct { string tag; vec_t v; } exp_t;
    typedef struct {
        logic [5:0]      opc;
        logic            zz;
        logic [PC_W-1:0] pcs;
        vec_t            v;
    } step_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [5:0]      opcode;
    logic            z;
    logic [PC_W-1:0] pc_sig;
    logic            s_inc, s_pila, s_inm, we3, wez;
    logic [2:0]      op;
    logic [PC_W-1:0] pc_ret;
    logic [PW-1:0]   prof;
    logic            err_pila, parado;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    unidad_control_pila #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .pc_sig(pc_sig), .s_inc(s_inc), .s_pila(s_pila),
        .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .pc_ret(pc_ret), .prof(prof), .err_pila(err_pila),
        .parado(parado)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int si, int sp, int sm, int w3, int wz,
                                int o, int r, int p, int e, int pa);
        return {si[0], sp[0], sm[0], w3[0], wz[0], o[2:0],
                r[PC_W-1:0], p[PW-1:0], e[0], pa[0]};
    endfunction

    function automatic step_t stp(int opc, int zz, int pcs, vec_t v);
        step_t s;
        s.opc = opc[5:0];
        s.zz  = zz[0];
        s.pcs = pcs[PC_W-1:0];
        s.v   = v;
        return s;
    endfunction

    function automatic vec_t obs();
        return {s_inc, s_pila, s_inm, we3, wez, op, pc_ret, prof,
                err_pila, parado};
    endfunction

    task automatic test_reset();
        exp_t e;
        reset  = 1'b1;
        opcode = 6'b000000;
        z      = 1'b0;
        pc_sig = '0;
        #2;
        sb.push_back('{"reset", mk(1,0,0,0,0,0,0,0,0,0)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_decode();
        step_t st[$];
        exp_t  e;
        st.push_back(stp('b101100, 0, 0, mk(1,0,0,1,1,3,0,0,0,0)));
        st.push_back(stp('b111111, 1, 0, mk(1,0,0,1,1,7,0,0,0,0)));
        st.push_back(stp('b000101, 0, 0, mk(1,0,1,1,0,0,0,0,0,0)));
        st.push_back(stp('b001110, 0, 0, mk(1,0,1,1,0,2,0,0,0,0)));
        st.push_back(stp('b011111, 0, 0, mk(1,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010000, 0, 0, mk(0,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010001, 1, 0, mk(0,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010001, 0, 0, mk(1,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010010, 1, 0, mk(1,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010010, 0, 0, mk(0,0,0,0,0,0,0,0,0,0)));
        foreach (st[i]) begin
            @(posedge clk);
            #1;
            opcode = st[i].opc;
            z      = st[i].zz;
            pc_sig = st[i].pcs;
            sb.push_back('{$sformatf("decode%0d", i), st[i].v});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
            end
        end
    endtask

    task automatic test_call_ret();
        step_t st[$];
        exp_t  e;
        st.push_back(stp('b010011, 0, 'h005, mk(0,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010011, 0, 'h013, mk(0,0,0,0,0,0,'h005,1,0,0)));
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,'h013,2,0,0)));
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,'h005,1,0,0)));
        st.push_back(stp('b000000, 0, 0, mk(1,0,0,0,0,0,0,0,0,0)));
        foreach (st[i]) begin
            @(posedge clk);
            #1;
            opcode = st[i].opc;
            z      = st[i].zz;
            pc_sig = st[i].pcs;
            sb.push_back('{$sformatf("callret%0d", i), st[i].v});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        exp_t  e;
        st.push_back(stp('b010011, 0, 'h0a1, mk(0,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,'h0a1,1,0,0)));
        st.push_back(stp('b010011, 0, 'h0b2, mk(0,0,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b010011, 0, 'h3c3, mk(0,0,0,0,0,0,'h0b2,1,0,0)));
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,'h3c3,2,0,0)));
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,'h0b2,1,0,0)));
        st.push_back(stp('b000000, 0, 0, mk(1,0,0,0,0,0,0,0,0,0)));
        foreach (st[i]) begin
            @(posedge clk);
            #1;
            opcode = st[i].opc;
            z      = st[i].zz;
            pc_sig = st[i].pcs;
            sb.push_back('{$sformatf("b2b%0d", i), st[i].v});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
            end
        end
    endtask

    task automatic test_overflow();
        step_t st[$];
        exp_t  e;
        for (int k = 1; k <= 5; k++)
            st.push_back(stp('b010011, 0, k,
                             mk(0,0,0,0,0,0,k-1,k-1,0,0)));
        st.push_back(stp('b000000, 0, 0, mk(1-H,0,0,0,0,0,4,4,1,H)));
        st.push_back(stp('b101100, 0, 0,
                         mk(1-H,0,0,1-H,1-H,3*(1-H),4,4,1,H)));
        foreach (st[i]) begin
            @(posedge clk);
            #1;
            opcode = st[i].opc;
            z      = st[i].zz;
            pc_sig = st[i].pcs;
            sb.push_back('{$sformatf("ovf%0d", i), st[i].v});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
            end
        end
        opcode = 6'b000000;
        #1;
        reset = 1'b1;
        #1;
        sb.push_back('{"ovf_async_rst", mk(1,0,0,0,0,0,0,0,0,0)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
        end
        reset = 1'b0;
    endtask

    task automatic test_underflow();
        step_t st[$];
        exp_t  e;
        st.push_back(stp('b010100, 0, 0, mk(0,1,0,0,0,0,0,0,0,0)));
        st.push_back(stp('b000000, 0, 0, mk(1-H,0,0,0,0,0,0,0,1,H)));
        st.push_back(stp('b010100, 0, 0, mk(0,1-H,0,0,0,0,0,0,1,H)));
        foreach (st[i]) begin
            @(posedge clk);
            #1;
            opcode = st[i].opc;
            z      = st[i].zz;
            pc_sig = st[i].pcs;
            sb.push_back('{$sformatf("udf%0d", i), st[i].v});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
            end
        end
        opcode = 6'b000000;
        #1;
        reset = 1'b1;
        #1;
        sb.push_back('{"udf_async_rst", mk(1,0,0,0,0,0,0,0,0,0)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got %h expected %h", e.tag, obs(), e.v);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_call_ret();
        test_back_to_back();
        test_overflow();
        test_underflow();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
